matmul_seq_ctrl: RTL and testbench

//  Sequencer for the matrix-multiply datapath: computes C = A x B with A (MxN), B (NxP), C (MxP).
//  All three matrices are row-major, 8-bit elements in the shared single-port DRAM.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/matmul_seq_ctrl_if.sv | 34 +++
 rtl/matmul_addr_gen.sv | 110 +++++++++++
 rtl/matmul_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the matrix-multiply sequencer.
// Imported by the controller, its address generator and the MAC.
package matmul_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIM_W  = 8;
  localparam int DEF_ACC_W  = 24;

  localparam logic [15:0] DEF_A_BASE = 16'h0000;
  localparam logic [15:0] DEF_B_BASE = 16'h0012;
  localparam logic [15:0] DEF_C_BASE = 16'h0024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_MAC,
    S_WR_C,
    S_DONE
  } state_e;

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// DRAM and MAC bus of the sequencer, named from the controller's side.
// master = sequencer, slave = DRAM/MAC side.
interface matmul_seq_ctrl_if
  import matmul_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic [ADDR_W-1:0] o_dram_addr;
  logic              o_dram_rd;
  logic              o_dram_wr;
  logic [DATA_W-1:0] o_dram_wdata;
  logic [DATA_W-1:0] i_dram_rdata;
  logic [DATA_W-1:0] o_mac_a;
  logic [DATA_W-1:0] o_mac_b;
  logic              o_mac_en;
  logic              o_mac_first;
  logic [ACC_W-1:0]  i_mac_result;

  modport master (
    output o_dram_addr, o_dram_rd, o_dram_wr, o_dram_wdata,
    output o_mac_a, o_mac_b, o_mac_en, o_mac_first,
    input  i_dram_rdata, i_mac_result
  );

  modport slave (
    input  o_dram_addr, o_dram_rd, o_dram_wr, o_dram_wdata,
    input  o_mac_a, o_mac_b, o_mac_en, o_mac_first,
    output i_dram_rdata, i_mac_result
  );

endinterface

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters and incremental A/B/C address pointers.
// No multipliers: every address is stepped from the previous one.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(DEF_A_BASE),
  parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(DEF_B_BASE),
  parameter logic [ADDR_W-1:0] C_BASE = ADDR_W'(DEF_C_BASE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              step_k_i,
  input  logic              step_elem_i,
  input  logic [DIM_W-1:0]  dim_m_i,
  input  logic [DIM_W-1:0]  dim_n_i,
  input  logic [DIM_W-1:0]  dim_p_i,
  output logic              k_first_o,
  output logic              k_last_o,
  output logic              elem_last_o,
  output logic [ADDR_W-1:0] a_ptr_o,
  output logic [ADDR_W-1:0] b_ptr_o,
  output logic [ADDR_W-1:0] c_ptr_o
);

  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] a_row_q, a_row_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] c_ptr_q, c_ptr_d;
  logic              col_last;
  logic              row_last;

  assign col_last    = col_q == dim_p_i - DIM_W'(1);
  assign row_last    = row_q == dim_m_i - DIM_W'(1);
  assign k_first_o   = k_q == '0;
  assign k_last_o    = k_q == dim_n_i - DIM_W'(1);
  assign elem_last_o = col_last & row_last;
  assign a_ptr_o     = a_ptr_q;
  assign b_ptr_o     = b_ptr_q;
  assign c_ptr_o     = c_ptr_q;

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    a_row_d = a_row_q;
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    c_ptr_d = c_ptr_q;
    unique case (1'b1)
      init_i: begin
        row_d   = '0;
        col_d   = '0;
        k_d     = '0;
        a_row_d = A_BASE;
        a_ptr_d = A_BASE;
        b_ptr_d = B_BASE;
        c_ptr_d = C_BASE;
      end
      step_k_i: begin
        k_d     = k_q + DIM_W'(1);
        a_ptr_d = a_ptr_q + ADDR_W'(1);
        b_ptr_d = b_ptr_q + ADDR_W'(dim_p_i);
      end
      step_elem_i: begin
        k_d     = '0;
        c_ptr_d = c_ptr_q + ADDR_W'(1);
        if (!col_last) begin
          col_d   = col_q + DIM_W'(1);
          a_ptr_d = a_row_q;
          b_ptr_d = B_BASE + ADDR_W'(col_q) + ADDR_W'(1);
        end else if (!row_last) begin
          // next A row starts N past the current one
          col_d   = '0;
          row_d   = row_q + DIM_W'(1);
          a_row_d = a_row_q + ADDR_W'(dim_n_i);
          a_ptr_d = a_row_q + ADDR_W'(dim_n_i);
          b_ptr_d = B_BASE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      a_row_q <= '0;
      a_ptr_q <= '0;
      b_ptr_q <= '0;
      c_ptr_q <= '0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      a_row_q <= a_row_d;
      a_ptr_q <= a_ptr_d;
      b_ptr_q <= b_ptr_d;
      c_ptr_q <= c_ptr_d;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for C = A x B: walks i/j/k, reads A/B from DRAM,
// drives the external MAC and writes each truncated C element back.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(DEF_A_BASE),
  parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(DEF_B_BASE),
  parameter logic [ADDR_W-1:0] C_BASE = ADDR_W'(DEF_C_BASE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [DIM_W-1:0] i_dim_m,
  input  logic [DIM_W-1:0] i_dim_n,
  input  logic [DIM_W-1:0] i_dim_p,
  output logic             o_busy,
  output logic             o_done,
  matmul_seq_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic              start_q;
  logic [DIM_W-1:0]  m_q, n_q, p_q;
  logic [DATA_W-1:0] a_q;
  logic              init, step_k, step_elem;
  logic              k_first, k_last, elem_last;
  logic [ADDR_W-1:0] a_ptr, b_ptr, c_ptr;
  logic              start_edge;
  logic              unused_acc_hi;

  assign start_edge    = i_start & ~start_q;
  assign unused_acc_hi = ^bus.i_mac_result[ACC_W-1:DATA_W];

  matmul_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .A_BASE (A_BASE),
    .B_BASE (B_BASE),
    .C_BASE (C_BASE)
  ) u_addr_gen (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .init_i      (init),
    .step_k_i    (step_k),
    .step_elem_i (step_elem),
    .dim_m_i     (m_q),
    .dim_n_i     (n_q),
    .dim_p_i     (p_q),
    .k_first_o   (k_first),
    .k_last_o    (k_last),
    .elem_last_o (elem_last),
    .a_ptr_o     (a_ptr),
    .b_ptr_o     (b_ptr),
    .c_ptr_o     (c_ptr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= i_start;
      if (init) begin
        m_q <= i_dim_m;
        n_q <= i_dim_n;
        p_q <= i_dim_p;
      end
      if (state_q == S_RD_B) a_q <= bus.i_dram_rdata;
    end
  end

  always_comb begin
    state_d          = state_q;
    init             = 1'b0;
    step_k           = 1'b0;
    step_elem        = 1'b0;
    o_busy           = state_q != S_IDLE;
    o_done           = 1'b0;
    bus.o_dram_addr  = '0;
    bus.o_dram_rd    = 1'b0;
    bus.o_dram_wr    = 1'b0;
    bus.o_dram_wdata = '0;
    bus.o_mac_a      = '0;
    bus.o_mac_b      = '0;
    bus.o_mac_en     = 1'b0;
    bus.o_mac_first  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          init = 1'b1;
          if (i_dim_m == '0 || i_dim_n == '0 || i_dim_p == '0)
            state_d = S_DONE;
          else
            state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        bus.o_dram_addr = a_ptr;
        bus.o_dram_rd   = 1'b1;
        state_d         = S_RD_B;
      end
      S_RD_B: begin
        bus.o_dram_addr = b_ptr;
        bus.o_dram_rd   = 1'b1;
        state_d         = S_MAC;
      end
      S_MAC: begin
        // B operand comes straight from the DRAM read port
        bus.o_mac_en    = 1'b1;
        bus.o_mac_first = k_first;
        bus.o_mac_a     = a_q;
        bus.o_mac_b     = bus.i_dram_rdata;
        if (k_last) begin
          state_d = S_WR_C;
        end else begin
          step_k  = 1'b1;
          state_d = S_RD_A;
        end
      end
      S_WR_C: begin
        bus.o_dram_addr  = c_ptr;
        bus.o_dram_wr    = 1'b1;
        bus.o_dram_wdata = bus.i_mac_result[DATA_W-1:0];
        step_elem        = 1'b1;
        state_d          = elem_last ? S_DONE : S_RD_A;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl with DRAM and MAC models.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dm = '0, dn = '0, dp = '0;
  logic       busy, done;

  matmul_seq_ctrl_if bus ();

  matmul_seq_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_dim_m (dm),
    .i_dim_n (dn),
    .i_dim_p (dp),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:255];
  logic [7:0]  rdata_q = '0;
  logic [23:0] acc_q = '0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_a = '0, ld_d = '0;

  assign bus.i_dram_rdata = rdata_q;
  assign bus.i_mac_result = acc_q;

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (bus.o_dram_wr) mem[bus.o_dram_addr[7:0]] <= bus.o_dram_wdata;
    if (bus.o_dram_rd) rdata_q <= mem[bus.o_dram_addr[7:0]];
    if (bus.o_mac_en)
      acc_q <= bus.o_mac_first ?
               24'(bus.o_mac_a) * 24'(bus.o_mac_b) :
               acc_q + 24'(bus.o_mac_a) * 24'(bus.o_mac_b);
  end

  int n_busy = 0, n_rd = 0, n_wr = 0, n_mac = 0, n_first = 0, n_both = 0;
  logic [15:0] rd_log [$];

  always @(negedge clk) begin
    if (busy) n_busy <= n_busy + 1;
    if (bus.o_dram_rd) n_rd <= n_rd + 1;
    if (bus.o_dram_wr) n_wr <= n_wr + 1;
    if (bus.o_mac_en) n_mac <= n_mac + 1;
    if (bus.o_mac_en & bus.o_mac_first) n_first <= n_first + 1;
    if (bus.o_dram_rd & bus.o_dram_wr) n_both <= n_both + 1;
    if (bus.o_dram_rd) rd_log.push_back(bus.o_dram_addr);
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ld(input logic [7:0] a, input logic [7:0] d);
    ld_en = 1'b1;
    ld_a  = a;
    ld_d  = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  logic [7:0] a3 [0:5]  = '{8'h12, 8'hF3, 8'h07, 8'h9C, 8'h41, 8'hD8};
  logic [7:0] b3 [0:11] = '{8'h05, 8'h11, 8'h80, 8'hFF, 8'h2A, 8'h03,
                            8'h7E, 8'h01, 8'hC4, 8'h39, 8'h00, 8'h66};
  logic [7:0] c3 [0:17];

  task automatic load3();
    for (int i = 0; i < 6; i++) ld(8'(i), a3[i]);
    for (int i = 0; i < 12; i++) ld(8'(8'h12 + i), b3[i]);
    for (int i = 0; i < 18; i++) ld(8'(8'h24 + i), 8'h00);
  endtask

  task automatic check3(input string tag);
    for (int i = 0; i < 18; i++)
      chk($sformatf("%s_c%0d", tag, i), 32'(mem[8'h24 + i]), 32'(c3[i]));
  endtask

  task automatic run(input logic [7:0] m, input logic [7:0] n,
                     input logic [7:0] p, input bit hold, output int bc);
    bit seen;
    int b0;
    seen = 1'b0;
    dm = m;
    dn = n;
    dp = p;
    #1;
    b0 = n_busy;
    start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      if (c == 0 && !hold) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    bc = n_busy - b0;
  endtask

  initial begin
    int bc, r0, w0, m0, f0, b0;
    bit hit;

    for (int i = 0; i < 256; i++) ld(8'(i), 8'h00);
    #1;
    chk("rst_out", {busy, done, bus.o_dram_rd, bus.o_dram_wr, bus.o_mac_en,
                    bus.o_mac_first}, 32'd0);
    chk("rst_bus", {bus.o_dram_addr, bus.o_mac_a, bus.o_mac_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst", 32'(busy), 32'd0);

    // single-element run, cycle by cycle
    ld(8'h00, 8'd3);
    ld(8'h12, 8'd5);
    dm = 8'd1; dn = 8'd1; dp = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t2_rda", {bus.o_dram_rd, bus.o_dram_wr, bus.o_dram_addr}, {2'b10, 16'h0000});
    @(negedge clk);
    chk("t2_rdb", {bus.o_dram_rd, bus.o_dram_wr, bus.o_dram_addr}, {2'b10, 16'h0012});
    @(negedge clk);
    chk("t2_mac", {bus.o_mac_en, bus.o_mac_first, bus.o_mac_a, bus.o_mac_b},
        {2'b11, 8'd3, 8'd5});
    @(negedge clk);
    chk("t2_wr", {bus.o_dram_wr, bus.o_dram_rd, bus.o_dram_addr, bus.o_dram_wdata},
        {2'b10, 16'h0024, 8'h0F});
    @(negedge clk);
    chk("t2_done", {busy, done}, 32'b11);
    @(negedge clk);
    chk("t2_idle", {busy, done}, 32'b00);
    chk("t2_mem", 32'(mem[8'h24]), 32'h0F);

    // 3x2 by 2x6
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 6; c++) begin
        logic [7:0] s;
        s = '0;
        for (int k = 0; k < 2; k++) s = s + a3[r*2+k] * b3[k*6+c];
        c3[r*6+c] = s;
      end
    load3();
    #1;
    r0 = rd_log.size();
    b0 = n_both;
    run(8'd3, 8'd2, 8'd6, 1'b0, bc);
    chk("t3_busy", 32'(bc), 32'd127);
    check3("t3");
    chk("t3_b01_k0", 32'(rd_log[r0+5]), 32'h13);
    chk("t3_b01_k1", 32'(rd_log[r0+7]), 32'h19);
    chk("t3_rdwr", 32'(n_both - b0), 32'd0);

    // truncation and mac_first every element
    ld(8'h00, 8'h10); ld(8'h01, 8'h10);
    ld(8'h12, 8'h10); ld(8'h13, 8'h10);
    for (int i = 0; i < 4; i++) ld(8'(8'h24 + i), 8'hAA);
    #1;
    m0 = n_mac;
    f0 = n_first;
    run(8'd2, 8'd1, 8'd2, 1'b0, bc);
    chk("t4_busy", 32'(bc), 32'd17);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t4_c%0d", i), 32'(mem[8'h24 + i]), 32'h00);
    chk("t4_mac", 32'(n_mac - m0), 32'd4);
    chk("t4_first", 32'(n_first - f0), 32'd4);

    // zero dimension
    #1;
    r0 = n_rd; w0 = n_wr; m0 = n_mac;
    run(8'd2, 8'd0, 8'd3, 1'b0, bc);
    chk("t5_busy", 32'(bc), 32'd1);
    chk("t5_rwm", {8'(n_rd - r0), 8'(n_wr - w0), 8'(n_mac - m0)}, 32'd0);

    // start held high: only one run
    load3();
    run(8'd3, 8'd2, 8'd6, 1'b1, bc);
    chk("t6_busy", 32'(bc), 32'd127);
    check3("t6a");
    b0 = n_busy;
    repeat (20) @(negedge clk);
    #1;
    chk("t6_norestart", 32'(n_busy - b0), 32'd0);
    start = 1'b0;
    @(negedge clk);

    // reset during RD_B of element 5, then rerun
    for (int i = 0; i < 18; i++) ld(8'(8'h24 + i), 8'h00);
    dm = 8'd3; dn = 8'd2; dp = 8'd6;
    #1;
    r0 = rd_log.size();
    hit = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (c == 0) start = 1'b0;
      if (rd_log.size() - r0 == 22) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t6_reach_rdb", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {busy, bus.o_dram_rd, bus.o_dram_wr, bus.o_mac_en,
                       bus.o_dram_addr}, 32'd0);
    chk("t6_c4_done", 32'(mem[8'h28]), 32'(c3[4]));
    chk("t6_c5_none", 32'(mem[8'h29]), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'd3, 8'd2, 8'd6, 1'b0, bc);
    chk("t6_rerun_busy", 32'(bc), 32'd127);
    check3("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
